// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue stage feeding the 32-bit ALU.
//   Resolves EX/MEM and MEM/WB operand forwarding when an op is accepted and
//   picks immediate or forwarded rt for operand B. The resolved op is latched
//   into a 2-entry skid buffer. The head entry drives the ALU directly.
//
// State table
//   state | meaning
//   EMPTY | no ops held; outValid=0, inReady=1
//   ONE   | head entry valid; inReady=1
//   FULL  | head + second entry valid; inReady=0
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   flush                     drop all buffered ops and the op offered this cycle
//   inValid/inReady           upstream handshake (inReady registered)
//   rsData, rtData, imm32     operand sources from decode / regfile
//   useImm, shamtIn, aluSelIn operand-B select, shift amount, ALU select
//   rsAddr, rtAddr, rdAddr    source/destination register numbers
//   regWriteIn                op writes rdAddr
//   exmem*, memwb*            forwarding sources from later stages
//   outValid/outReady         downstream handshake
//   x32bit, y32bit, shiftAmount, sel, rdOut, regWriteOut   head entry fields
module alu_issue_stage #(
  parameter int DEPTH_LOG2 = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        inValid,
  output logic        inReady,
  input  logic [31:0] rsData,
  input  logic [31:0] rtData,
  input  logic [31:0] imm32,
  input  logic        useImm,
  input  logic [4:0]  shamtIn,
  input  logic [3:0]  aluSelIn,
  input  logic [4:0]  rsAddr,
  input  logic [4:0]  rtAddr,
  input  logic [4:0]  rdAddr,
  input  logic        regWriteIn,
  input  logic        exmemRegWrite,
  input  logic [4:0]  exmemRd,
  input  logic [31:0] exmemRes,
  input  logic        memwbRegWrite,
  input  logic [4:0]  memwbRd,
  input  logic [31:0] memwbData,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] x32bit,
  output logic [31:0] y32bit,
  output logic [4:0]  shiftAmount,
  output logic [3:0]  sel,
  output logic [4:0]  rdOut,
  output logic        regWriteOut
);

  localparam logic [1:0] FULL_CNT = 2'(1 << DEPTH_LOG2);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = FULL_CNT
  } state_t;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  shamt;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        rw;
  } entry_t;

  state_t      state;
  entry_t      head;
  entry_t      second;
  entry_t      incoming;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;
  logic        accept;
  logic        pop;

  // $0 is never forwarded; EX/MEM has priority over MEM/WB.
  always_comb begin
    fwd_rs = rsData;
    if (rsAddr != 5'd0) begin
      if (exmemRegWrite && exmemRd == rsAddr)      fwd_rs = exmemRes;
      else if (memwbRegWrite && memwbRd == rsAddr) fwd_rs = memwbData;
    end
  end

  always_comb begin
    fwd_rt = rtData;
    if (rtAddr != 5'd0) begin
      if (exmemRegWrite && exmemRd == rtAddr)      fwd_rt = exmemRes;
      else if (memwbRegWrite && memwbRd == rtAddr) fwd_rt = memwbData;
    end
  end

  always_comb begin
    incoming.x     = fwd_rs;
    incoming.y     = useImm ? imm32 : fwd_rt;
    incoming.shamt = shamtIn;
    incoming.sel   = aluSelIn;
    incoming.rd    = rdAddr;
    incoming.rw    = regWriteIn;
  end

  assign accept = inValid & inReady & ~flush;
  assign pop    = outValid & outReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      head     <= '0;
      second   <= '0;
      outValid <= 1'b0;
      inReady  <= 1'b1;
    end else if (flush) begin
      // Data registers keep their contents; only occupancy is cleared.
      state    <= EMPTY;
      outValid <= 1'b0;
      inReady  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head     <= incoming;
            state    <= ONE;
            outValid <= 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head <= incoming;
          end else if (accept) begin
            second  <= incoming;
            state   <= FULL;
            inReady <= 1'b0;
          end else if (pop) begin
            state    <= EMPTY;
            outValid <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            head    <= second;
            state   <= ONE;
            inReady <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          outValid <= 1'b0;
          inReady  <= 1'b1;
        end
      endcase
    end
  end

  assign x32bit      = head.x;
  assign y32bit      = head.y;
  assign shiftAmount = head.shamt;
  assign sel         = head.sel;
  assign rdOut       = head.rd;
  assign regWriteOut = head.rw;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] rsData = '0, rtData = '0, imm32 = '0;
  logic        useImm = 1'b0;
  logic [4:0]  shamtIn = '0;
  logic [3:0]  aluSelIn = '0;
  logic [4:0]  rsAddr = '0, rtAddr = '0, rdAddr = '0;
  logic        regWriteIn = 1'b0;
  logic        exmemRegWrite = 1'b0;
  logic [4:0]  exmemRd = '0;
  logic [31:0] exmemRes = '0;
  logic        memwbRegWrite = 1'b0;
  logic [4:0]  memwbRd = '0;
  logic [31:0] memwbData = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] x32bit, y32bit;
  logic [4:0]  shiftAmount;
  logic [3:0]  sel;
  logic [4:0]  rdOut;
  logic        regWriteOut;

  int total = 0;
  int bad = 0;
  int pops = 0;

  // {x, y, shamt, sel, rd, rw}
  logic [78:0] sb[$];

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .inValid(inValid), .inReady(inReady),
    .rsData(rsData), .rtData(rtData), .imm32(imm32), .useImm(useImm),
    .shamtIn(shamtIn), .aluSelIn(aluSelIn), .rsAddr(rsAddr), .rtAddr(rtAddr),
    .rdAddr(rdAddr), .regWriteIn(regWriteIn), .exmemRegWrite(exmemRegWrite),
    .exmemRd(exmemRd), .exmemRes(exmemRes), .memwbRegWrite(memwbRegWrite),
    .memwbRd(memwbRd), .memwbData(memwbData), .outValid(outValid),
    .outReady(outReady), .x32bit(x32bit), .y32bit(y32bit),
    .shiftAmount(shiftAmount), .sel(sel), .rdOut(rdOut), .regWriteOut(regWriteOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [78:0] act, input logic [78:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a head consumed at the coming edge must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got x=%h y=%h with no op expected", x32bit, y32bit);
      end else begin
        check("pop_order", {x32bit, y32bit, shiftAmount, sel, rdOut, regWriteOut},
              sb.pop_front());
        pops++;
      end
    end
  end

  // Called just after a posedge; returns just after the accepting edge.
  task automatic send(input logic [4:0] rs, input logic [4:0] rt,
                      input logic [31:0] rsd, input logic [31:0] rtd,
                      input logic [31:0] imm, input logic ui,
                      input logic [4:0] sh, input logic [3:0] s,
                      input logic [4:0] rd, input logic rw,
                      input logic [31:0] ex, input logic [31:0] ey);
    logic rdy;
    int   n;
    rsAddr = rs; rtAddr = rt; rsData = rsd; rtData = rtd; imm32 = imm;
    useImm = ui; shamtIn = sh; aluSelIn = s; rdAddr = rd; regWriteIn = rw;
    inValid = 1'b1;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 60) begin
      @(negedge clk);
      rdy = inReady;
      @(posedge clk);
      n++;
    end
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got inReady=0 for %0d cycles, expected 1", n);
    end else begin
      sb.push_back({ex, ey, sh, s, rd, rw});
    end
    #1 inValid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 79'(sb.size()), 79'd0);
  endtask

  initial begin
    int p0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_state", {x32bit, y32bit, shiftAmount, sel, rdOut, regWriteOut},
          79'd0);
    check("reset_hs", 79'({outValid, inReady}), 79'b01);

    // 1: plain op, visible after the accepting edge
    outReady = 1'b1;
    send(5'd3, 5'd4, 32'd5, 32'd7, 32'd0, 1'b0, 5'd2, 4'b0000, 5'd9, 1'b1,
         32'd5, 32'd7);
    check("latency_head", {47'd0, outValid, x32bit}, {47'd0, 1'b1, 32'd5});
    drain("drain_t1");

    // 2: EX/MEM beats MEM/WB; MEM/WB used when EX/MEM not writing
    exmemRegWrite = 1'b1; exmemRd = 5'd3; exmemRes = 32'hAA;
    memwbRegWrite = 1'b1; memwbRd = 5'd3; memwbData = 32'hBB;
    send(5'd3, 5'd4, 32'd5, 32'd7, 32'd0, 1'b0, 5'd0, 4'b0001, 5'd8, 1'b1,
         32'hAA, 32'd7);
    exmemRegWrite = 1'b0;
    send(5'd3, 5'd4, 32'd5, 32'd7, 32'd0, 1'b0, 5'd0, 4'b0010, 5'd8, 1'b1,
         32'hBB, 32'd7);
    // rt forwarded from MEM/WB, rs from register file
    memwbRd = 5'd4;
    send(5'd6, 5'd4, 32'h11, 32'h22, 32'd0, 1'b0, 5'd31, 4'b1010, 5'd1, 1'b0,
         32'h11, 32'hBB);
    drain("drain_t2");

    // 3: $0 never forwarded
    exmemRegWrite = 1'b1; exmemRd = 5'd0; exmemRes = 32'hFF;
    memwbRegWrite = 1'b1; memwbRd = 5'd0; memwbData = 32'hEE;
    send(5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'b0011, 5'd2, 1'b1,
         32'd0, 32'd0);
    drain("drain_t3");

    // 5: immediate wins over a matching rt forward
    exmemRd = 5'd5; exmemRes = 32'h1234;
    memwbRegWrite = 1'b0;
    send(5'd7, 5'd5, 32'h77, 32'h55, 32'hFFFFFFFC, 1'b1, 5'd4, 4'b0100, 5'd3, 1'b1,
         32'h77, 32'hFFFFFFFC);
    drain("drain_t5");
    exmemRegWrite = 1'b0;

    // 4: back-pressure, three ops, order kept
    outReady = 1'b0;
    p0 = pops;
    send(5'd1, 5'd2, 32'h101, 32'h201, 32'd0, 1'b0, 5'd1, 4'b0101, 5'd11, 1'b1,
         32'h101, 32'h201);
    check("one_ready", 79'(inReady), 79'd1);
    send(5'd1, 5'd2, 32'h102, 32'h202, 32'd0, 1'b0, 5'd2, 4'b0110, 5'd12, 1'b1,
         32'h102, 32'h202);
    check("full_ready", 79'(inReady), 79'd0);
    fork
      send(5'd1, 5'd2, 32'h103, 32'h203, 32'd0, 1'b0, 5'd3, 4'b0111, 5'd13, 1'b0,
           32'h103, 32'h203);
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("hold_stable", {46'd0, outValid, inReady, x32bit}, {46'd0, 2'b10, 32'h101});
    outReady = 1'b1;
    repeat (8) @(posedge clk);
    drain("drain_t4");
    check("t4_pop_count", 79'(pops - p0), 79'd3);

    // 6: flush on a full buffer with an op offered
    outReady = 1'b0;
    send(5'd1, 5'd2, 32'h301, 32'h401, 32'd0, 1'b0, 5'd0, 4'b1000, 5'd21, 1'b1,
         32'h301, 32'h401);
    send(5'd1, 5'd2, 32'h302, 32'h402, 32'd0, 1'b0, 5'd0, 4'b1001, 5'd22, 1'b1,
         32'h302, 32'h402);
    rsData = 32'hDEAD; inValid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; inValid = 1'b0;
    sb.delete();
    check("flush_hs", 79'({outValid, inReady}), 79'b01);
    outReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("flush_idle", 79'(outValid), 79'd0);
    send(5'd9, 5'd10, 32'h501, 32'h601, 32'd0, 1'b0, 5'd5, 4'b0001, 5'd23, 1'b1,
         32'h501, 32'h601);
    drain("drain_post_flush");

    // reset mid-stream
    outReady = 1'b0;
    send(5'd9, 5'd10, 32'h701, 32'h801, 32'd0, 1'b0, 5'd6, 4'b0010, 5'd24, 1'b1,
         32'h701, 32'h801);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    check("rst_mid_state", {x32bit, y32bit, shiftAmount, sel, rdOut, regWriteOut},
          79'd0);
    check("rst_mid_hs", 79'({outValid, inReady}), 79'b01);
    outReady = 1'b1;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
